// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared encodings and helpers for the cache/memory burst arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GRANT_IC = 2'd1;
    localparam logic [1:0] ST_GRANT_DC = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        GRANT_IC = ST_GRANT_IC,
        GRANT_DC = ST_GRANT_DC
    } state_t;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    // One extra bit so a full burst count of BURST_LEN is representable.
    function automatic int BEAT_CNT_WIDTH(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_beat_counter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_beat_counter
// Brief    : Counts burst beats during a grant and flags a burst overrun.
// Revision : 1.0
// ============================================================================
module mem_arb_beat_counter
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic i_Clk,
    input  logic i_Reset_n,
    input  logic i_Enable,
    input  logic i_Beat,
    input  logic i_Last,
    output logic o_Overrun
);

    localparam int CNT_W = BEAT_CNT_WIDTH(BURST_LEN);
    localparam logic [CNT_W-1:0] c_FINAL_IDX = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;
    logic             w_beat;

    assign w_beat = i_Enable && i_Beat;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_count <= '0;
        end else if (w_beat) begin
            if (i_Last) begin
                r_count <= '0;
            end else if (r_count != c_CNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // The beat that brings the count to BURST_LEN without Last is the overrun.
    assign o_Overrun = w_beat && !i_Last && (r_count >= c_FINAL_IDX);

endmodule : mem_arb_beat_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Per-burst arbiter sharing one memory port between I- and D-cache.
//            Define MEM_ARB_RR_EN for round-robin tie-breaking (else DC wins).
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 22,
    parameter int BURST_LEN  = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    input  logic                  i_IC_MEM_Valid,
    input  logic [ADDR_WIDTH-1:0] i_IC_MEM_Address,
    output logic                  o_IC_MEM_Valid,
    output logic                  o_IC_MEM_Last,
    output logic [DATA_WIDTH-1:0] o_IC_MEM_Data,
    input  logic                  i_DC_MEM_Valid,
    input  logic                  i_DC_MEM_Write,
    input  logic [ADDR_WIDTH-1:0] i_DC_MEM_Address,
    input  logic [DATA_WIDTH-1:0] i_DC_MEM_Data,
    output logic                  o_DC_MEM_Valid,
    output logic                  o_DC_MEM_Last,
    output logic [DATA_WIDTH-1:0] o_DC_MEM_Data,
    output logic                  o_MEM_Valid,
    output logic                  o_MEM_Write,
    output logic [ADDR_WIDTH-1:0] o_MEM_Address,
    output logic [DATA_WIDTH-1:0] o_MEM_Data,
    input  logic                  i_MEM_Valid,
    input  logic                  i_MEM_Last,
    input  logic [DATA_WIDTH-1:0] i_MEM_Data,
    output logic                  o_Busy,
    output logic                  o_Protocol_Err
);

    state_t r_state;
    state_t w_next;
    logic   r_err;
    logic   w_pick_dc;
    logic   w_overrun;
    logic   w_err_set;
    logic   w_granted;

    assign w_granted = (r_state != IDLE);

`ifdef MEM_ARB_RR_EN
    logic r_last_owner;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_last_owner <= OWNER_IC;
        end else if (r_state == IDLE && w_next == GRANT_DC) begin
            r_last_owner <= OWNER_DC;
        end else if (r_state == IDLE && w_next == GRANT_IC) begin
            r_last_owner <= OWNER_IC;
        end
    end

    assign w_pick_dc = (r_last_owner == OWNER_IC);
`else
    assign w_pick_dc = 1'b1;
`endif

    mem_arb_beat_counter #(
        .BURST_LEN (BURST_LEN)
    ) u_beat_counter (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .i_Enable  (w_granted),
        .i_Beat    (i_MEM_Valid),
        .i_Last    (i_MEM_Last),
        .o_Overrun (w_overrun)
    );

    assign w_err_set = ((r_state == IDLE) && i_MEM_Valid) || w_overrun;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_DC_MEM_Valid && (!i_IC_MEM_Valid || w_pick_dc)) begin
                    w_next = GRANT_DC;
                end else if (i_IC_MEM_Valid) begin
                    w_next = GRANT_IC;
                end
            end
            GRANT_IC, GRANT_DC: begin
                if (i_MEM_Valid && i_MEM_Last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Memory beats reach only the owner; the other cache sees a quiet port.
    always_comb begin
        o_IC_MEM_Valid = 1'b0;
        o_IC_MEM_Last  = 1'b0;
        o_IC_MEM_Data  = '0;
        o_DC_MEM_Valid = 1'b0;
        o_DC_MEM_Last  = 1'b0;
        o_DC_MEM_Data  = '0;
        o_MEM_Valid    = 1'b0;
        o_MEM_Write    = 1'b0;
        o_MEM_Address  = '0;
        o_MEM_Data     = '0;
        case (r_state)
            GRANT_IC: begin
                o_MEM_Valid    = i_IC_MEM_Valid;
                o_MEM_Address  = i_IC_MEM_Address;
                o_MEM_Data     = i_DC_MEM_Data;
                o_IC_MEM_Valid = i_MEM_Valid;
                o_IC_MEM_Last  = i_MEM_Last;
                o_IC_MEM_Data  = i_MEM_Data;
            end
            GRANT_DC: begin
                o_MEM_Valid    = i_DC_MEM_Valid;
                o_MEM_Write    = i_DC_MEM_Write;
                o_MEM_Address  = i_DC_MEM_Address;
                o_MEM_Data     = i_DC_MEM_Data;
                o_DC_MEM_Valid = i_MEM_Valid;
                o_DC_MEM_Last  = i_MEM_Last;
                o_DC_MEM_Data  = i_MEM_Data;
            end
            default: ;
        endcase
    end

    assign o_Busy         = w_granted;
    assign o_Protocol_Err = r_err;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench: directed bursts, expected events queued and
//            popped by a negedge monitor. Honours MEM_ARB_RR_EN.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 22;
    localparam logic [1:0] K_REQ = 2'd0;
    localparam logic [1:0] K_IC  = 2'd1;
    localparam logic [1:0] K_DC  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic        wr;
        logic        last;
        logic [31:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ic_valid, dc_valid, dc_write;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [DW-1:0] dc_data;
    logic          mem_valid, mem_last;
    logic [DW-1:0] mem_data;

    logic          o_IC_MEM_Valid, o_IC_MEM_Last, o_DC_MEM_Valid, o_DC_MEM_Last;
    logic [DW-1:0] o_IC_MEM_Data, o_DC_MEM_Data, o_MEM_Data;
    logic          o_MEM_Valid, o_MEM_Write, o_Busy, o_Protocol_Err;
    logic [AW-1:0] o_MEM_Address;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic mem_v_prev = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(4)) dut (
        .i_Clk            (clk),
        .i_Reset_n        (rst_n),
        .i_IC_MEM_Valid   (ic_valid),
        .i_IC_MEM_Address (ic_addr),
        .o_IC_MEM_Valid   (o_IC_MEM_Valid),
        .o_IC_MEM_Last    (o_IC_MEM_Last),
        .o_IC_MEM_Data    (o_IC_MEM_Data),
        .i_DC_MEM_Valid   (dc_valid),
        .i_DC_MEM_Write   (dc_write),
        .i_DC_MEM_Address (dc_addr),
        .i_DC_MEM_Data    (dc_data),
        .o_DC_MEM_Valid   (o_DC_MEM_Valid),
        .o_DC_MEM_Last    (o_DC_MEM_Last),
        .o_DC_MEM_Data    (o_DC_MEM_Data),
        .o_MEM_Valid      (o_MEM_Valid),
        .o_MEM_Write      (o_MEM_Write),
        .o_MEM_Address    (o_MEM_Address),
        .o_MEM_Data       (o_MEM_Data),
        .i_MEM_Valid      (mem_valid),
        .i_MEM_Last       (mem_last),
        .i_MEM_Data       (mem_data),
        .o_Busy           (o_Busy),
        .o_Protocol_Err   (o_Protocol_Err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_pop(input logic [1:0] kind, input logic [31:0] val,
                           input logic wr, input logic last, input string name);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s unexpected: actual %h required none (t=%0t)", name, val, $time);
        end else begin
            e = q.pop_front();
            chk({name, " kind"}, 32'(kind), 32'(e.kind));
            chk({name, " val"},  val, e.val);
            chk({name, " wr"},   32'(wr), 32'(e.wr));
            chk({name, " last"}, 32'(last), 32'(e.last));
        end
    endtask

    // Monitor: every new memory request and every steered beat pops one entry.
    always @(negedge clk) begin
        if (o_MEM_Valid && !mem_v_prev)
            mon_pop(K_REQ, 32'(o_MEM_Address), o_MEM_Write, 1'b0, "req");
        if (o_IC_MEM_Valid)
            mon_pop(K_IC, o_IC_MEM_Data, 1'b0, o_IC_MEM_Last, "ic_beat");
        if (o_DC_MEM_Valid)
            mon_pop(K_DC, o_DC_MEM_Data, 1'b0, o_DC_MEM_Last, "dc_beat");
        mem_v_prev = o_MEM_Valid;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] kind, input logic wr, input logic last, input logic [31:0] val);
        exp_t e;
        e.kind = kind; e.wr = wr; e.last = last; e.val = val;
        q.push_back(e);
    endtask

    task automatic req_grant(input logic [AW-1:0] addr, input logic wr);
        push(K_REQ, wr, 1'b0, 32'(addr));
        tick();
        chk("grant busy", 32'(o_Busy), 32'd1);
        chk("grant mem_valid", 32'(o_MEM_Valid), 32'd1);
    endtask

    task automatic burst(input logic to_dc, input int n, input logic [31:0] base,
                         input logic wr, input logic end_last);
        for (int i = 0; i < n; i++) begin
            mem_valid = 1'b1;
            mem_last  = end_last && (i == n - 1);
            mem_data  = wr ? 32'd0 : base + 32'(i);
            if (wr) dc_data = base + 32'(i);
            push(to_dc ? K_DC : K_IC, 1'b0, mem_last, wr ? 32'd0 : base + 32'(i));
            #1;
            if (wr) chk("wb o_MEM_Data", o_MEM_Data, base + 32'(i));
            tick();
        end
        mem_valid = 1'b0;
        mem_last  = 1'b0;
        mem_data  = '0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, " busy"},      32'(o_Busy), 32'd0);
        chk({name, " mem_valid"}, 32'(o_MEM_Valid), 32'd0);
        chk({name, " mem_addr"},  32'(o_MEM_Address), 32'd0);
        chk({name, " ic_valid"},  32'(o_IC_MEM_Valid), 32'd0);
        chk({name, " dc_valid"},  32'(o_DC_MEM_Valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ic_valid = 0; dc_valid = 0; dc_write = 0;
        ic_addr = '0; dc_addr = '0; dc_data = '0;
        mem_valid = 0; mem_last = 0; mem_data = '0;
        repeat (3) tick();
        chk_idle("reset");
        chk("reset err", 32'(o_Protocol_Err), 32'd0);
        rst_n = 1'b1;
        tick();

        // IC-only fill
        ic_valid = 1'b1; ic_addr = 22'h00040;
        #1 chk("ic latency", 32'(o_MEM_Valid), 32'd0);
        req_grant(22'h00040, 1'b0);
        burst(1'b0, 4, 32'hA0, 1'b0, 1'b1);
        ic_valid = 1'b0;
        #1 chk_idle("after ic fill");

        // Simultaneous requests; DC keeps requesting after its first burst
        tick();
        ic_valid = 1'b1; ic_addr = 22'h00080;
        dc_valid = 1'b1; dc_addr = 22'h00200; dc_write = 1'b0;
        req_grant(22'h00200, 1'b0);
        chk("tie1 addr", 32'(o_MEM_Address), 32'h200);
        burst(1'b1, 4, 32'hB0, 1'b0, 1'b1);
        dc_addr = 22'h00240;
        #1 chk("gap idle", 32'(o_Busy), 32'd0);
`ifdef MEM_ARB_RR_EN
        req_grant(22'h00080, 1'b0);
        burst(1'b0, 4, 32'hC0, 1'b0, 1'b1);
        ic_addr = 22'h000C0;
        req_grant(22'h00240, 1'b0);
        burst(1'b1, 4, 32'hD0, 1'b0, 1'b1);
        dc_valid = 1'b0;
        req_grant(22'h000C0, 1'b0);
        burst(1'b0, 4, 32'hE0, 1'b0, 1'b1);
        ic_valid = 1'b0;
`else
        req_grant(22'h00240, 1'b0);
        burst(1'b1, 4, 32'hD0, 1'b0, 1'b1);
        dc_valid = 1'b0;
        req_grant(22'h00080, 1'b0);
        burst(1'b0, 4, 32'hC0, 1'b0, 1'b1);
        ic_valid = 1'b0;
`endif
        tick();

        // DC write-back
        dc_valid = 1'b1; dc_write = 1'b1; dc_addr = 22'h00100;
        req_grant(22'h00100, 1'b1);
        burst(1'b1, 4, 32'h11, 1'b1, 1'b1);
        dc_valid = 1'b0; dc_write = 1'b0; dc_data = '0;
        tick();

        // Reset in the middle of an IC fill
        ic_valid = 1'b1; ic_addr = 22'h00300;
        req_grant(22'h00300, 1'b0);
        burst(1'b0, 2, 32'hF0, 1'b0, 1'b0);
        rst_n = 1'b0; ic_valid = 1'b0;
        tick();
        chk_idle("mid reset");
        rst_n = 1'b1;
        dc_valid = 1'b1; dc_addr = 22'h00400;
        req_grant(22'h00400, 1'b0);
        burst(1'b1, 4, 32'h60, 1'b0, 1'b1);
        dc_valid = 1'b0;
        tick();

        // Stray memory beat while idle
        chk("pre stray err", 32'(o_Protocol_Err), 32'd0);
        mem_valid = 1'b1; mem_data = 32'hDEAD;
        tick();
        mem_valid = 1'b0; mem_data = '0;
        chk("stray err set", 32'(o_Protocol_Err), 32'd1);
        repeat (3) tick();
        chk("stray err sticky", 32'(o_Protocol_Err), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("err cleared", 32'(o_Protocol_Err), 32'd0);
        tick();

        // Overrun: owner drops early, beats still steered, err at 4th beat
        ic_valid = 1'b1; ic_addr = 22'h00500;
        req_grant(22'h00500, 1'b0);
        burst(1'b0, 2, 32'h70, 1'b0, 1'b0);
        ic_valid = 1'b0;
        #1 chk("owner drop mem_valid", 32'(o_MEM_Valid), 32'd0);
        burst(1'b0, 1, 32'h72, 1'b0, 1'b0);
        chk("beat3 err", 32'(o_Protocol_Err), 32'd0);
        burst(1'b0, 1, 32'h73, 1'b0, 1'b0);
        chk("beat4 err", 32'(o_Protocol_Err), 32'd1);
        chk("beat4 busy", 32'(o_Busy), 32'd1);
        burst(1'b0, 1, 32'h74, 1'b0, 1'b0);
        chk("beat5 busy", 32'(o_Busy), 32'd1);
        burst(1'b0, 1, 32'h75, 1'b0, 1'b1);
        chk("after late last busy", 32'(o_Busy), 32'd0);
        chk("err still set", 32'(o_Protocol_Err), 32'd1);

        repeat (2) tick();
        chk("queue drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
